uart_transmitter: RTL and testbench

UART_TRANSMITTER -- requirements
Module: uart_transmitter

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_gen.sv | 40 ++++
 rtl/uart_transmitter.sv | 117 +++++++++++
 tb/tb_uart_transmitter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter: FSM states, default rates, bit-period helper.
package uart_pkg;

  localparam int unsigned DEF_CLK_FREQ_HZ = 100_000_000;
  localparam int unsigned DEF_BAUD_RATE   = 9600;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } tx_state_e;

  // Rounded integer division so non-integral ratios land on the nearest clock count.
  function automatic int unsigned calc_divisor(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: one-clock bit_tick_o every DIVISOR clocks while enabled, synchronously restartable.
module uart_baud_gen #(
  parameter int unsigned DIVISOR = 10417
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic restart_i,
  output logic bit_tick_o
);

  localparam int unsigned CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap;

  assign wrap       = (cnt_q == CW'(DIVISOR - 1));
  assign bit_tick_o = en_i && !restart_i && wrap;

  // Counter parks at zero when disabled so each frame starts from a clean period.
  always_comb begin
    cnt_d = cnt_q;
    if (restart_i || !en_i) begin
      cnt_d = '0;
    end else if (wrap) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter, 8N1 LSB first; an even-parity bit is inserted when UART_TX_PARITY_EN is defined.
// Tx/busy change on the accepting edge (1-clock latency); trans_en is ignored while busy.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
  parameter int unsigned BAUD_RATE   = DEF_BAUD_RATE
) (
  input  logic       input_clk,
  input  logic       reset,
  input  logic       trans_en,
  input  logic [7:0] data_out,
  output logic       Tx,
  output logic       busy
);

  localparam int unsigned DIVISOR = calc_divisor(CLK_FREQ_HZ, BAUD_RATE);

  tx_state_e  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] idx_q, idx_d;
  logic       restart;
  logic       bit_tick;
`ifdef UART_TX_PARITY_EN
  logic       par_q, par_d;
`endif

  assign busy = (state_q != IDLE);

  uart_baud_gen #(.DIVISOR(DIVISOR)) u_baud_gen (
    .clk_i      (input_clk),
    .rst_i      (reset),
    .en_i       (busy),
    .restart_i  (restart),
    .bit_tick_o (bit_tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    restart = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (trans_en) begin
          state_d = START;
          shift_d = data_out;
          idx_d   = 3'd0;
          restart = 1'b1;
`ifdef UART_TX_PARITY_EN
          par_d   = ^data_out;
`endif
        end
      end
      START: begin
        if (bit_tick) state_d = DATA;
      end
      DATA: begin
        if (bit_tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_tick) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Line level decoded from registered state only, so reset forces it high immediately.
  always_comb begin
    Tx = 1'b1;
    case (state_q)
      START:   Tx = 1'b0;
      DATA:    Tx = shift_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  Tx = par_q;
`endif
      default: Tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter with a short bit period (round(1000/77) = 13 clocks).
module tb_uart_transmitter;

  localparam int unsigned CLK_HZ = 1000;
  localparam int unsigned BAUD   = 77;
  localparam int DIV = 13;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       input_clk = 1'b0;
  logic       reset     = 1'b0;
  logic       trans_en  = 1'b0;
  logic [7:0] data_out  = 8'h00;
  logic       Tx;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  uart_transmitter #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD)) dut (
    .input_clk (input_clk),
    .reset     (reset),
    .trans_en  (trans_en),
    .data_out  (data_out),
    .Tx        (Tx),
    .busy      (busy)
  );

  always #5 input_clk = ~input_clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // frame[s] is the hand-computed line level of slot s: start, d0..d7, stop (parity kept apart).
  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    logic       par;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge input_clk);
    #1;
  endtask

  // Caller has trans_en/data_out set up; the first edge here is the accepting edge.
  task automatic run_frame(input vec_t v, input bit hold, input int glitch_c, input string tag);
    logic [NBITS-1:0] exp;
    for (int s = 0; s < 9; s++) exp[s] = v.frame[s];
`ifdef UART_TX_PARITY_EN
    exp[9] = v.par;
`endif
    exp[NBITS-1] = v.frame[9];
    for (int s = 0; s < NBITS; s++) begin
      int bad_tx;
      int bad_busy;
      bad_tx   = 0;
      bad_busy = 0;
      for (int k = 0; k < DIV; k++) begin
        int c;
        c = s * DIV + k;
        tick();
        if (c == 0 && !hold) trans_en = 1'b0;
        if (glitch_c >= 0 && c == glitch_c) begin
          trans_en = 1'b1;
          data_out = 8'hFF;
        end
        if (glitch_c >= 0 && c == glitch_c + 2) trans_en = 1'b0;
        if (Tx !== exp[s]) bad_tx++;
        if (busy !== 1'b1) bad_busy++;
      end
      check($sformatf("%s slot%0d tx_wrong_cycles", tag, s), bad_tx, 0);
      check($sformatf("%s slot%0d busy_low_cycles", tag, s), bad_busy, 0);
    end
    tick();
    check($sformatf("%s end busy", tag), busy, 0);
    check($sformatf("%s end tx", tag), Tx, 1);
  endtask

  task automatic idle_window(input int n, input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (busy !== 1'b0 || Tx !== 1'b1) bad++;
    end
    check($sformatf("%s non_idle_cycles", tag), bad, 0);
  endtask

  initial begin
    int errs;
    vecs[0] = '{8'h55, 10'b1_01010101_0, 1'b0};
    vecs[1] = '{8'hA3, 10'b1_10100011_0, 1'b0};
    vecs[2] = '{8'h00, 10'b1_00000000_0, 1'b0};
    vecs[3] = '{8'hFF, 10'b1_11111111_0, 1'b0};
    vecs[4] = '{8'h0F, 10'b1_00001111_0, 1'b0};
    vecs[5] = '{8'h3C, 10'b1_00111100_0, 1'b0};
    vecs[6] = '{8'h81, 10'b1_10000001_0, 1'b0};
    vecs[7] = '{8'h07, 10'b1_00000111_0, 1'b1};
    vecs[8] = '{8'h03, 10'b1_00000011_0, 1'b0};

    #2 reset = 1'b1;
    repeat (3) tick();
    check("reset tx", Tx, 1);
    check("reset busy", busy, 0);
    reset = 1'b0;
    idle_window(2 * DIV, "post_reset idle");

    for (int i = 0; i < 9; i++) begin
      data_out = vecs[i].data;
      trans_en = 1'b1;
      run_frame(vecs[i], 1'b0, -1, $sformatf("vec%0d_%02h", i, vecs[i].data));
      idle_window(2, $sformatf("vec%0d gap", i));
    end

    // Second request and new data_out during DATA must be ignored.
    data_out = 8'hA3;
    trans_en = 1'b1;
    run_frame(vecs[1], 1'b0, 4 * DIV, "ignore_req");
    idle_window(2 * DIV, "ignore_req after");

    // Reset in the middle of data bit 4 of 0x0F.
    data_out = 8'h0F;
    trans_en = 1'b1;
    tick();
    trans_en = 1'b0;
    repeat (5 * DIV + 3) tick();
    check("midframe tx before reset", Tx, 0);
    check("midframe busy before reset", busy, 1);
    reset = 1'b1;
    #1;
    check("midframe reset tx", Tx, 1);
    check("midframe reset busy", busy, 0);
    tick();
    reset = 1'b0;
    idle_window(3 * DIV, "after_abort idle");
    data_out = 8'h3C;
    trans_en = 1'b1;
    run_frame(vecs[5], 1'b0, -1, "after_abort 3C");

    // trans_en held: one IDLE clock, then the next frame starts on the following edge.
    data_out = 8'h81;
    trans_en = 1'b1;
    run_frame(vecs[6], 1'b1, -1, "b2b first");
    run_frame(vecs[6], 1'b0, -1, "b2b second");
    idle_window(DIV, "b2b after");

    // Loopback: mid-bit sampling receiver, one frame per 12 bit periods.
    errs = 0;
    for (int b = 0; b < 256; b++) begin
      logic [NBITS-1:0] rx;
      rx = '0;
      data_out = 8'(b);
      trans_en = 1'b1;
      tick();
      trans_en = 1'b0;
      for (int c = 0; c < 12 * DIV; c++) begin
        if ((c % DIV) == (DIV / 2) && (c / DIV) < NBITS) rx[c / DIV] = Tx;
        tick();
      end
      if (rx[0] !== 1'b0 || rx[8:1] !== 8'(b) || rx[NBITS-1] !== 1'b1) errs++;
`ifdef UART_TX_PARITY_EN
      if (rx[9] !== ^(8'(b))) errs++;
`endif
    end
    check("loopback errors", errs, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
